// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder.
package bcd_pkg;

   // Controller states: accept in IDLE, one digit per cycle in ADD, report in DONE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Largest legal decimal digit; anything above it needs correction or is invalid.
   localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;

   // Added to a binary digit sum above 9 to skip the six unused 4-bit codes.
   localparam logic [3:0] BCD_CORRECTION = 4'd6;

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Request/result bundle between a requester and the serial BCD adder.
//
// Handshake: the requester raises start with A, B and Cin valid. The adder
// samples start only while busy is low; the edge that samples it also captures
// the operands, and busy rises. There is no queueing and no backpressure;
// start seen while busy is high is dropped. done is a single-cycle pulse
// marking the cycle in which Sum, Cout and err are final. Those outputs then
// hold until the next accepted start.
interface bcd_serial_add_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    start;
   logic [4*NUM_DIGITS-1:0] A;
   logic [4*NUM_DIGITS-1:0] B;
   logic                    Cin;
   logic                    busy;
   logic                    done;
   logic [4*NUM_DIGITS-1:0] Sum;
   logic                    Cout;
   logic                    err;

   modport master (
      output start, A, B, Cin,
      input  busy, done, Sum, Cout, err
   );

   modport slave (
      input  start, A, B, Cin,
      output busy, done, Sum, Cout, err
   );
endinterface

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: a + b + ci, with decimal correction.
// Digits above 9 on the inputs are not rejected here. They go through the same
// arithmetic, so 0xF + 0 gives digit 5 with carry 1.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [4:0] raw;

   // Binary add, then fold sums above 9 back into a decimal digit plus carry.
   always_comb begin
      raw = {1'b0, a} + {1'b0, b} + {4'd0, ci};
      if (raw > {1'b0, BCD_MAX_DIGIT}) begin
         s  = raw[3:0] + BCD_CORRECTION;
         co = 1'b1;
      end else begin
         s  = raw[3:0];
         co = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Serial BCD adder controller: one digit per clock, least significant first.
// Optional feature: define BCD_SERIAL_ADD_INVALID_CHECK_EN to reject operands
// that contain a digit above 9. A rejected request raises err, leaves Sum and
// Cout at 0, and reports done in the cycle after acceptance.
module bcd_serial_add_ctrl
   import bcd_pkg::*;
#(
   parameter int NUM_DIGITS = 4
)(
   input  logic                        clk,
   input  logic                        rst,
   bcd_serial_add_ctrl_if.slave        bus,
   output state_t                      state_dbg
);

   localparam int W  = 4 * NUM_DIGITS;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

   state_t          state;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [W-1:0]    sum_q;
   logic [IW-1:0]   idx;
   logic            carry;
   logic            cout_q;
   logic            done_q;
   logic            busy_q;
   logic            err_q;

   logic [3:0]      dig_a;
   logic [3:0]      dig_b;
   logic [3:0]      dig_s;
   logic            dig_co;

`ifdef BCD_SERIAL_ADD_INVALID_CHECK_EN
   // True when any digit of v lies outside 0..9.
   function automatic logic has_invalid_digit(input logic [W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (v[4*d +: 4] > BCD_MAX_DIGIT) bad = 1'b1;
      end
      return bad;
   endfunction
`endif

   // The current digit comes from the latched operands, so inputs may change mid-add.
   always_comb begin
      dig_a = a_q[{idx, 2'b00} +: 4];
      dig_b = b_q[{idx, 2'b00} +: 4];
   end

   bcd_digit_add u_digit (
      .a  (dig_a),
      .b  (dig_b),
      .ci (carry),
      .s  (dig_s),
      .co (dig_co)
   );

   // Controller FSM plus its operand, index, carry and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         sum_q  <= '0;
         idx    <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_q    <= bus.A;
                  b_q    <= bus.B;
                  carry  <= bus.Cin;
                  sum_q  <= '0;
                  cout_q <= 1'b0;
                  idx    <= '0;
                  busy_q <= 1'b1;
`ifdef BCD_SERIAL_ADD_INVALID_CHECK_EN
                  if (has_invalid_digit(bus.A) || has_invalid_digit(bus.B)) begin
                     err_q  <= 1'b1;
                     done_q <= 1'b1;
                     state  <= DONE;
                  end else begin
                     err_q  <= 1'b0;
                     state  <= ADD;
                  end
`else
                  err_q  <= 1'b0;
                  state  <= ADD;
`endif
               end
            end
            ADD: begin
               sum_q[{idx, 2'b00} +: 4] <= dig_s;
               carry                    <= dig_co;
               if (idx == LAST_IDX) begin
                  cout_q <= dig_co;
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.Sum  = sum_q;
   assign bus.Cout = cout_q;
   assign bus.done = done_q;
   assign bus.busy = busy_q;
   assign bus.err  = err_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl (NUM_DIGITS = 4).
// Compile with or without BCD_SERIAL_ADD_INVALID_CHECK_EN.
module tb_bcd_serial_add_ctrl;
   import bcd_pkg::*;

   logic   clk;
   logic   rst;
   state_t state_dbg;

   bcd_serial_add_ctrl_if #(.NUM_DIGITS(4)) bus ();

   bcd_serial_add_ctrl #(.NUM_DIGITS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   logic [15:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int busy_cnt;
   int done_cnt;
   int done_edge;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_sum(input string tag);
      logic [15:0] e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: got empty expected-queue expected entry", tag);
      end else begin
         e = exp_q.pop_front();
         check_val(tag, 32'(bus.Sum), 32'(e));
      end
   endtask

   // ---------------- driver ----------------
   // Issue one request and watch 10 cycles starting from the accepting edge (e = 0).
   // hold > 0 keeps start high until the negedge after edge 'hold'.
   // chg scrambles A/B/Cin after edge 1, while the add is in progress.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input int hold, input bit chg, input logic [15:0] exp_sum);
      @(negedge clk);
      bus.A     = a;
      bus.B     = b;
      bus.Cin   = cin;
      bus.start = 1'b1;
      exp_q.push_back(exp_sum);
      @(posedge clk);
      #1;
      if (hold == 0) bus.start = 1'b0;
      busy_cnt  = 0;
      done_cnt  = 0;
      done_edge = -1;
      for (int e = 0; e < 10; e++) begin
         @(negedge clk);
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            done_cnt++;
            done_edge = e;
         end
         if (chg && e == 1) begin
            bus.A   = 16'h9999;
            bus.B   = 16'h8888;
            bus.Cin = 1'b1;
         end
         if (hold > 0 && e == hold) bus.start = 1'b0;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      bus.Cin   = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_sum",   32'(bus.Sum),  32'h0);
      check_val("rst_cout",  32'(bus.Cout), 32'h0);
      check_val("rst_err",   32'(bus.err),  32'h0);
      check_val("rst_done",  32'(bus.done), 32'h0);
      check_val("rst_busy",  32'(bus.busy), 32'h0);
      check_val("rst_state", 32'(state_dbg), 32'(IDLE));
      rst = 1'b0;

      // Basic add: 1234 + 5678 = 6912
      run_op(16'h1234, 16'h5678, 1'b0, 0, 1'b0, 16'h6912);
      check_sum("basic_sum");
      check_val("basic_cout",  32'(bus.Cout), 32'h0);
      check_val("basic_err",   32'(bus.err),  32'h0);
      check_val("basic_dedge", 32'(done_edge), 32'd4);
      check_val("basic_dcnt",  32'(done_cnt),  32'd1);
      check_val("basic_busy",  32'(busy_cnt),  32'd5);
      check_val("basic_state", 32'(state_dbg), 32'(IDLE));

      // Result holds in IDLE
      repeat (3) @(negedge clk);
      check_val("hold_sum", 32'(bus.Sum), 32'h6912);

      // Full carry ripple: 9999 + 0000 + 1 = 1_0000
      run_op(16'h9999, 16'h0000, 1'b1, 0, 1'b0, 16'h0000);
      check_sum("ripple_sum");
      check_val("ripple_cout", 32'(bus.Cout), 32'h1);
      check_val("ripple_err",  32'(bus.err),  32'h0);

      // Mixed carries: 2819 + 3796 = 6615
      run_op(16'h2819, 16'h3796, 1'b0, 0, 1'b0, 16'h6615);
      check_sum("mixed_sum");
      check_val("mixed_cout", 32'(bus.Cout), 32'h0);

      // Carry-in only: 0 + 0 + 1 = 1
      run_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0, 16'h0001);
      check_sum("cin_sum");
      check_val("cin_cout", 32'(bus.Cout), 32'h0);

      // start held through the op, operands scrambled mid-add
      run_op(16'h0001, 16'h0001, 1'b0, 4, 1'b1, 16'h0002);
      check_sum("ign_sum");
      check_val("ign_dcnt",  32'(done_cnt), 32'd1);
      check_val("ign_busy",  32'(busy_cnt), 32'd5);
      check_val("ign_cout",  32'(bus.Cout), 32'h0);

      // Reset at edge 2 of an add
      @(negedge clk);
      bus.A     = 16'h1234;
      bus.B     = 16'h5678;
      bus.Cin   = 1'b0;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check_val("mrst_sum",   32'(bus.Sum),  32'h0);
      check_val("mrst_cout",  32'(bus.Cout), 32'h0);
      check_val("mrst_err",   32'(bus.err),  32'h0);
      check_val("mrst_done",  32'(bus.done), 32'h0);
      check_val("mrst_busy",  32'(bus.busy), 32'h0);
      check_val("mrst_state", 32'(state_dbg), 32'(IDLE));
      @(negedge clk);
      rst = 1'b0;
      done_cnt = 0;
      for (int e = 0; e < 6; e++) begin
         @(negedge clk);
         if (bus.done) done_cnt++;
      end
      check_val("mrst_nodone", 32'(done_cnt), 32'd0);
      run_op(16'h4321, 16'h1111, 1'b0, 0, 1'b0, 16'h5432);
      check_sum("post_rst_sum");
      check_val("post_rst_dedge", 32'(done_edge), 32'd4);

`ifdef BCD_SERIAL_ADD_INVALID_CHECK_EN
      // Invalid digit rejected at acceptance
      run_op(16'h12A4, 16'h0001, 1'b0, 0, 1'b0, 16'h0000);
      check_sum("inv_sum");
      check_val("inv_err",   32'(bus.err),   32'h1);
      check_val("inv_cout",  32'(bus.Cout),  32'h0);
      check_val("inv_dedge", 32'(done_edge), 32'd0);
      check_val("inv_busy",  32'(busy_cnt),  32'd1);
      run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0, 16'h0002);
      check_sum("inv_next_sum");
      check_val("inv_next_err", 32'(bus.err), 32'h0);
      // Nibble F is also rejected
      run_op(16'h000F, 16'h0000, 1'b0, 0, 1'b0, 16'h0000);
      check_sum("nibf_sum");
      check_val("nibf_err", 32'(bus.err), 32'h1);
`else
      // Invalid nibble processed arithmetically: F + 0 -> digit 5 carry 1
      run_op(16'h000F, 16'h0000, 1'b0, 0, 1'b0, 16'h0015);
      check_sum("nibf_sum");
      check_val("nibf_cout", 32'(bus.Cout), 32'h0);
      check_val("nibf_err",  32'(bus.err),  32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
